// File: rtl/debug_unit.sv
// debug_unit: UART-driven program loader, run/step control and register/memory dumper for the MIPS pipeline
// Optional feature macro: DUNIT_PC_DUMP_EN (prefix every dump with the captured PC).
// Ports:
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_rx_data, i_rx_valid           received command/data byte and its strobe
//   o_tx_data, o_tx_start, i_tx_done byte to send, send strobe, previous-byte-done strobe
//   i_end_program                   pipeline reached HALT
//   i_dunit_reg, i_dunit_mem_data   register-file / data-memory read data (1-cycle latency)
//   i_dunit_pc                      current PC (dumped only with DUNIT_PC_DUMP_EN)
//   o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem, o_dunit_addr, o_dunit_data_if  pipeline debug port
module debug_unit #(
  parameter int NB_REG = 32,
  parameter int NB_BYTE = 8,
  parameter int N_REGS = 32,
  parameter int N_MEM_WORDS = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  input  logic               i_end_program,
  input  logic [NB_REG-1:0]  i_dunit_reg,
  input  logic [NB_REG-1:0]  i_dunit_mem_data,
  input  logic [NB_REG-1:0]  i_dunit_pc,
  output logic               o_dunit_clk_en,
  output logic               o_dunit_reset_pc,
  output logic               o_dunit_w_mem,
  output logic [NB_REG-1:0]  o_dunit_addr,
  output logic [NB_REG-1:0]  o_dunit_data_if
);
`ifdef DUNIT_PC_DUMP_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int N_ITEMS = OFS + N_REGS + N_MEM_WORDS;
  localparam int IW = $clog2(N_ITEMS);
  localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_C = NB_BYTE'(8'h43);
  localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_R = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] ACK = NB_BYTE'(8'h06);
  localparam logic [NB_BYTE-1:0] NAK = NB_BYTE'(8'h15);

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SEL, DUMP_CAP, DUMP_TX, DUMP_WAIT
  } state_t;

  state_t state, nxt;
  logic [8:0] idx, n_words;
  logic [1:0] bcnt;
  logic [IW-1:0] item;
  logic [NB_REG-1:0] cap, shreg, ritem, dump_addr, pc_q;
  logic [NB_BYTE-1:0] resp_byte, resp_val;
  logic tx_busy, resp_pend, rpc, is_pc, is_reg, resp_set, tx_go, last_item, in_dump, last_word, known_cmd;

`ifdef DUNIT_PC_DUMP_EN
  assign is_pc = item == '0;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) pc_q <= '0;
    else pc_q <= (state == RUN || state == STEP) && nxt == DUMP_SEL ? i_dunit_pc : pc_q;
`else
  logic unused_pc;
  assign unused_pc = ^i_dunit_pc;
  assign is_pc = 1'b0;
  assign pc_q = '0;
`endif

  assign in_dump = state inside {DUMP_SEL, DUMP_CAP, DUMP_TX, DUMP_WAIT};
  assign last_item = item == IW'(N_ITEMS - 1);
  assign last_word = idx + 9'd1 == n_words;
  assign ritem = NB_REG'(item) - NB_REG'(OFS);
  assign is_reg = ritem < NB_REG'(N_REGS);
  assign dump_addr = is_pc ? '0 : is_reg ? ritem : (ritem - NB_REG'(N_REGS)) << 2;
  // a pending ACK/NAK goes out first; the dump only advances once the line is free
  assign tx_go = !tx_busy && !resp_pend;
  assign known_cmd = i_rx_data == CMD_L || i_rx_data == CMD_C || i_rx_data == CMD_S;
  assign resp_set = (state == IDLE && i_rx_valid && !known_cmd) || (state == LOAD_WRITE && last_word);
  assign resp_val = state == LOAD_WRITE || i_rx_data == CMD_R ? ACK : NAK;

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !i_rx_valid ? IDLE : i_rx_data == CMD_L ? LOAD_CNT : i_rx_data == CMD_C ? RUN :
                  i_rx_data == CMD_S ? STEP : IDLE;
      LOAD_CNT: nxt = i_rx_valid ? LOAD_BYTE : LOAD_CNT;
      LOAD_BYTE: nxt = i_rx_valid && bcnt == 2'd3 ? LOAD_WRITE : LOAD_BYTE;
      LOAD_WRITE: nxt = last_word ? IDLE : LOAD_BYTE;
      RUN: nxt = i_end_program ? DUMP_SEL : RUN;
      STEP: nxt = DUMP_SEL;
      DUMP_SEL: nxt = DUMP_CAP;
      DUMP_CAP: nxt = DUMP_TX;
      DUMP_TX: nxt = tx_go ? DUMP_WAIT : DUMP_TX;
      DUMP_WAIT: nxt = !i_tx_done ? DUMP_WAIT : bcnt != '0 ? DUMP_TX : last_item ? IDLE : DUMP_SEL;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      idx <= '0;
      n_words <= '0;
      bcnt <= '0;
      item <= '0;
      cap <= '0;
      shreg <= '0;
      tx_busy <= 1'b0;
      resp_pend <= 1'b0;
      resp_byte <= '0;
      rpc <= 1'b0;
    end else begin
      idx <= state == LOAD_CNT ? '0 : state == LOAD_WRITE ? idx + 9'd1 : idx;
      // a count byte of 0 means 256 words
      n_words <= state == LOAD_CNT && i_rx_valid ? {~|i_rx_data, i_rx_data} : n_words;
      bcnt <= state == LOAD_CNT ? '0 :
              (state == LOAD_BYTE && i_rx_valid) || (state == DUMP_TX && tx_go) ? bcnt + 2'd1 : bcnt;
      shreg <= state == LOAD_BYTE && i_rx_valid ? {shreg[NB_REG-NB_BYTE-1:0], i_rx_data} : shreg;
      cap <= state == DUMP_CAP ? (is_pc ? pc_q : is_reg ? i_dunit_reg : i_dunit_mem_data) :
             state == DUMP_TX && tx_go ? cap << NB_BYTE : cap;
      item <= state == DUMP_WAIT && i_tx_done && bcnt == '0 ? (last_item ? '0 : item + 1'b1) :
              in_dump ? item : '0;
      tx_busy <= o_tx_start ? 1'b1 : i_tx_done ? 1'b0 : tx_busy;
      resp_pend <= resp_set ? 1'b1 : o_tx_start ? 1'b0 : resp_pend;
      resp_byte <= resp_set ? resp_val : resp_byte;
      rpc <= state == IDLE && i_rx_valid && i_rx_data == CMD_R;
    end

  always_comb begin
    o_dunit_clk_en = state == STEP || (state == RUN && !i_end_program);
    o_dunit_reset_pc = rpc || state inside {LOAD_CNT, LOAD_BYTE, LOAD_WRITE};
    o_dunit_w_mem = state == LOAD_WRITE;
    o_dunit_addr = state == LOAD_WRITE ? NB_REG'({idx, 2'b00}) : in_dump ? dump_addr : '0;
    o_dunit_data_if = shreg;
    o_tx_start = !tx_busy && (resp_pend || state == DUMP_TX);
    o_tx_data = resp_pend ? resp_byte : cap[NB_REG-1 -: NB_BYTE];
  end
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: randomized directed checks of debug_unit against a byte-level reference model
module tb_debug_unit;
`ifdef DUNIT_PC_DUMP_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif
  localparam int TOT = 4 * (OFS + 32 + 16);

  logic clk = 0, rst = 1, rx_valid = 0, tx_done = 0, end_prog = 0;
  logic [7:0] rx_data = 0, tx_data;
  logic [31:0] reg_rd = 0, mem_rd = 0, pc = 0, addr, dif;
  logic tx_start, clk_en, rpc, wmem;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .i_end_program(end_prog), .i_dunit_reg(reg_rd), .i_dunit_mem_data(mem_rd),
    .i_dunit_pc(pc), .o_dunit_clk_en(clk_en), .o_dunit_reset_pc(rpc),
    .o_dunit_w_mem(wmem), .o_dunit_addr(addr), .o_dunit_data_if(dif)
  );

  int ncmp = 0, nerr = 0;
  logic [31:0] regs[32], mem[16], prog[256];
  logic [7:0] tx_log[4096];
  logic [31:0] w_addr[512], w_data[512];
  int n_tx = 0, n_ovl = 0, dly = 0, n_clken = 0, n_rpc = 0, n_bad = 0, n_w = 0;
  bit busy = 0;

  // register file and data memory with one-cycle read latency
  always @(posedge clk) begin
    reg_rd <= regs[addr[4:0]];
    mem_rd <= mem[addr[5:2]];
  end

  // UART transmitter: random completion delay, flags a start while a byte is still in flight
  always @(negedge clk) begin
    bit wb;
    wb = busy;
    tx_done = 0;
    if (rst) busy = 0;
    else begin
      if (busy) begin
        if (dly == 0) begin tx_done = 1; busy = 0; end
        else dly--;
      end
      if (tx_start) begin
        if (wb) n_ovl++;
        if (n_tx < 4096) tx_log[n_tx] = tx_data;
        n_tx++;
        busy = 1;
        dly = $urandom_range(0, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (clk_en) n_clken++;
    if (rpc) n_rpc++;
    if (wmem) begin
      if (n_w < 512) begin w_addr[n_w] = addr; w_data[n_w] = dif; end
      n_w++;
      if (!rpc || clk_en) n_bad++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int c = 0;
    while (n_tx < target && c < budget) begin @(negedge clk); c++; end
    check({tag, "_timeout"}, 32'(n_tx >= target), 32'd1);
  endtask

  task automatic randomize_state();
    regs[0] = 0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    pc = OFS ? 32'h40 : $urandom;
  endtask

  task automatic load(input int n);
    int w0 = n_w, t0 = n_tx, b0 = n_bad;
    send(8'h4C);
    send(8'(n % 256));
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) send(prog[w][31-8*k -: 8]);
    wait_tx(t0 + 1, 200, "load_ack");
    check("load_ack", 32'(tx_log[t0]), 32'h06);
    check("load_nwrites", n_w - w0, n);
    for (int w = 0; w < n; w++) begin
      check($sformatf("load_addr%0d", w), w_addr[w0+w], 32'(w * 4));
      check($sformatf("load_data%0d", w), w_data[w0+w], prog[w]);
    end
    check("load_wmem_ctx", n_bad - b0, 0);
    @(negedge clk);
    check("load_rpc_dropped", 32'(rpc), 0);
  endtask

  task automatic dump(input string tag, input int t0);
    int r0 = n_rpc, w0 = n_w, r;
    logic [31:0] wd;
    wait_tx(t0 + 4, 500, tag);
    send(8'h4C);
    send(8'h52);
    wait_tx(t0 + TOT, 4000, tag);
    repeat (20) @(negedge clk);
    check({tag, "_len"}, n_tx - t0, TOT);
    for (int i = 0; i < TOT / 4; i++) begin
      r = i - OFS;
      wd = r < 0 ? pc : r < 32 ? regs[r] : mem[r-32];
      for (int k = 0; k < 4; k++)
        check($sformatf("%s_byte%0d", tag, 4*i+k), 32'(tx_log[t0+4*i+k]), 32'(wd[31-8*k -: 8]));
    end
    check({tag, "_rx_ignored_rpc"}, n_rpc - r0, 0);
    check({tag, "_rx_ignored_wmem"}, n_w - w0, 0);
  endtask

  initial begin
    int t0, c0, r0, n;
    randomize_state();
    repeat (3) @(negedge clk);
    check("rst_clk_en", 32'(clk_en), 0);
    check("rst_reset_pc", 32'(rpc), 0);
    check("rst_w_mem", 32'(wmem), 0);
    check("rst_addr", addr, 0);
    check("rst_data_if", dif, 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    rst = 0;

    send(8'h4C); send(8'h02); send(8'hAA); send(8'hBB);
    check("midload_rpc", 32'(rpc), 1);
    @(posedge clk);
    #3 rst = 1;
    #1;
    check("async_rst_rpc", 32'(rpc), 0);
    check("async_rst_data_if", dif, 0);
    check("async_rst_addr", addr, 0);
    check("async_rst_w_mem", 32'(wmem), 0);
    @(negedge clk);
    rst = 0;
    check("no_partial_write", n_w, 0);

    t0 = n_tx; c0 = n_clken; r0 = n_rpc;
    send(8'h7A);
    wait_tx(t0 + 1, 100, "nak");
    repeat (5) @(negedge clk);
    check("nak_byte", 32'(tx_log[t0]), 32'h15);
    check("nak_count", n_tx - t0, 1);
    check("nak_clk_en", n_clken - c0, 0);
    check("nak_rpc", n_rpc - r0, 0);
    check("nak_wmem", n_w, 0);

    prog[0] = 32'h2006000B;
    prog[1] = 32'h08000010;
    load(2);

    t0 = n_tx; r0 = n_rpc;
    send(8'h52);
    wait_tx(t0 + 1, 100, "r_ack");
    check("r_ack", 32'(tx_log[t0]), 32'h06);
    check("r_rpc_pulse", n_rpc - r0, 1);

    c0 = n_clken; t0 = n_tx;
    send(8'h53);
    dump("step", t0);
    check("step_clk_en", n_clken - c0, 1);

    randomize_state();
    c0 = n_clken; t0 = n_tx;
    @(negedge clk);
    rx_data = 8'h43;
    rx_valid = 1;
    @(posedge clk);
    #1 rx_valid = 0;
    repeat (7) @(posedge clk);
    #1 end_prog = 1;
    dump("run", t0);
    check("run_clk_en", n_clken - c0, 7);

    randomize_state();
    c0 = n_clken; t0 = n_tx;
    send(8'h43);
    dump("run_halted", t0);
    check("run_halted_clk_en", n_clken - c0, 0);
    end_prog = 0;

    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) prog[w] = $urandom;
      load(n);
    end

    for (int w = 0; w < 256; w++) prog[w] = $urandom;
    load(256);

    randomize_state();
    c0 = n_clken; t0 = n_tx;
    send(8'h53);
    dump("step2", t0);
    check("step2_clk_en", n_clken - c0, 1);

    check("tx_overlap", n_ovl, 0);
    check("wmem_ctx_total", n_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Host-side controller upstream of the pipeline. It drives the pipeline's debug port (clock enable, PC reset, instruction-memory write, address, data) and reads back the register file and data memory. It decodes single-byte commands from a UART receiver and streams state dumps to a UART transmitter. All program loading, run control and state readback of the MIPS core go through this block.

Parameters:
NB_REG, 32, datapath / debug word width
NB_BYTE, 8, UART byte width
N_REGS, 32, registers dumped (indices 0..N_REGS-1)
N_MEM_WORDS, 16, data-memory words dumped (byte addresses 0,4,..)

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_rx_data  in  NB_BYTE  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_tx_data  out  NB_BYTE  byte to send
o_tx_start  out  1  one-cycle strobe, start sending o_tx_data
i_tx_done  in  1  one-cycle strobe, previous byte sent
i_end_program  in  1  pipeline reached HALT (level)
i_dunit_reg  in  NB_REG  register-file read data at o_dunit_addr[4:0]
i_dunit_mem_data  in  NB_REG  data-memory read data at o_dunit_addr
i_dunit_pc  in  NB_REG  current PC (used only with optional feature)
o_dunit_clk_en  out  1  pipeline advance enable
o_dunit_reset_pc  out  1  hold PC at 0
o_dunit_w_mem  out  1  instruction-memory write strobe
o_dunit_addr  out  NB_REG  write address / read select
o_dunit_data_if  out  NB_REG  instruction word to write

Behaviour:
- One clock i_clk. i_reset is asynchronous, active-high. On reset: all outputs 0; FSM to IDLE; counters and shift register cleared.
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WRITE, RUN, STEP, DUMP_SEL, DUMP_CAP, DUMP_TX, DUMP_WAIT.
- IDLE: wait for i_rx_valid. Decode the byte:
  - 0x4C 'L' -> LOAD_CNT.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x52 'R' -> pulse o_dunit_reset_pc for 1 cycle, send 0x06 (ACK), return to IDLE.
  - Any other byte -> send 0x15 (NAK), stay in IDLE.
- LOAD_CNT: next byte is word count N; 0 means 256. Word index cleared. o_dunit_reset_pc held 1 for the whole load.
- LOAD_BYTE: shift in 4 bytes, MSB first, into o_dunit_data_if. After the 4th byte -> LOAD_WRITE.
- LOAD_WRITE: o_dunit_w_mem=1 for exactly 1 cycle with o_dunit_addr = index*4. Index increments.
  - If index==N: send ACK, drop reset_pc, go to IDLE.
  - Otherwise: back to LOAD_BYTE.
- RUN: o_dunit_clk_en=1 every cycle until i_end_program is sampled 1. clk_en is 0 in the cycle after detection -> DUMP_SEL. If i_end_program is already 1 on entry, clk_en is never asserted.
- STEP: o_dunit_clk_en=1 for exactly one cycle -> DUMP_SEL.
- Dump sequence: registers 0..N_REGS-1 (o_dunit_addr=i), then memory words 0..N_MEM_WORDS-1 (o_dunit_addr=j*4).
  - DUMP_SEL: drive the address.
  - DUMP_CAP: next cycle, capture i_dunit_reg or i_dunit_mem_data; read latency is 1 cycle.
  - DUMP_TX: pulse o_tx_start with o_tx_data = byte k of the captured word, MSB first.
  - DUMP_WAIT: wait for i_tx_done. After 4 bytes go to the next item; after the last item go to IDLE with o_dunit_addr=0.
  - Total bytes = 4*(N_REGS+N_MEM_WORDS) = 192 at defaults.
- Every transmitted byte, ACK/NAK included, waits for i_tx_done before the next o_tx_start. At most one o_tx_start is outstanding.
- i_rx_valid in any state other than IDLE, LOAD_CNT or LOAD_BYTE is ignored and the byte is dropped.
- o_dunit_clk_en is 0 in every state except RUN and STEP. o_dunit_w_mem is never 1 while clk_en is 1.
- Reset mid-load or mid-dump aborts immediately. A partially shifted word is never written.

Optional Feature:
DUNIT_PC_DUMP_EN
- Defined: the dump is prefixed with i_dunit_pc, captured at DUMP_SEL entry and sent as 4 bytes MSB first. Total bytes = 4*(1+N_REGS+N_MEM_WORDS).
- Undefined: i_dunit_pc is ignored and the dump starts with register 0.

Test Plan:
- Reset with i_reset asserted asynchronously mid-cycle -> all outputs 0 immediately; FSM in IDLE after release.
- Send 0x4C,0x02, then bytes 20 06 00 0B and 08 00 00 10 -> w_mem pulses with (addr 0x0, data 0x2006000B) then (addr 0x4, data 0x08000010); reset_pc=1 throughout; ACK 0x06 sent.
- After the load, send 'S' -> clk_en high exactly 1 cycle; 192 bytes sent, first 4 = register 0 = 00 00 00 00; address sequence 0..31, then 0x0..0x3C.
- Send 'C' with i_end_program rising 7 cycles later -> clk_en high 7 cycles, then dump starts; rx bytes during the dump are ignored.
- Send 0x7A -> NAK 0x15; no debug outputs change.
- With DUNIT_PC_DUMP_EN and i_dunit_pc=0x40, send 'S' -> 196 bytes, first four 00 00 00 40.
